// File: rtl/tia_pkg.sv
// ---------------------------------------------------------------------------
// tia_pkg
// Shared constants and types for the TIA object position counters.
//   NUSIZ_*              number/size codes written to NUSIZx
//   PLAYER_COUNT_PERIOD  position counts per 160-pixel line (4 pixels each)
//   COPY_CLOSE/MED/FAR   counts at which the extra copies start
//   width_t              pixel-width scale selected by a number/size code
// ---------------------------------------------------------------------------
package tia_pkg;

  localparam logic [2:0] NUSIZ_ONE         = 3'b000;
  localparam logic [2:0] NUSIZ_TWO_CLOSE   = 3'b001;
  localparam logic [2:0] NUSIZ_TWO_MED     = 3'b010;
  localparam logic [2:0] NUSIZ_THREE_CLOSE = 3'b011;
  localparam logic [2:0] NUSIZ_TWO_WIDE    = 3'b100;
  localparam logic [2:0] NUSIZ_DOUBLE      = 3'b101;
  localparam logic [2:0] NUSIZ_THREE_MED   = 3'b110;
  localparam logic [2:0] NUSIZ_QUAD        = 3'b111;

  localparam logic [5:0] PLAYER_COUNT_PERIOD = 6'd40;

  localparam logic [5:0] COPY_CLOSE = 6'd4;
  localparam logic [5:0] COPY_MED   = 6'd8;
  localparam logic [5:0] COPY_FAR   = 6'd16;

  typedef enum logic [1:0] {
    WIDTH_1X = 2'd0,
    WIDTH_2X = 2'd1,
    WIDTH_4X = 2'd2
  } width_t;

endpackage

// File: rtl/tia_player_copy_decode.sv
// ---------------------------------------------------------------------------
// tia_player_copy_decode
// Combinational copy-start decode shared by the player and missile position
// counters.
//   position   in  6  current position count (0..39)
//   nusiz      in  3  number/size code
//   supp       in  1  suppress the main copy (count 0) after a reposition
//   raw_start  out 1  high when a copy starts at this count
//   width_sel  out 2  pixel-width scale for the scan-counter step rate
// ---------------------------------------------------------------------------
module tia_player_copy_decode
  import tia_pkg::*;
(
  input  logic [5:0] position,
  input  logic [2:0] nusiz,
  input  logic       supp,
  output logic       raw_start,
  output width_t     width_sel
);

  logic copy_close;
  logic copy_med;
  logic copy_far;

  // Translate the number/size code into which extra copies exist and how
  // wide each pixel is. The wide-pixel codes only ever draw the main copy.
  always_comb begin
    copy_close = 1'b0;
    copy_med   = 1'b0;
    copy_far   = 1'b0;
    width_sel  = WIDTH_1X;
    case (nusiz)
      NUSIZ_ONE:         ;
      NUSIZ_TWO_CLOSE:   copy_close = 1'b1;
      NUSIZ_TWO_MED:     copy_med   = 1'b1;
      NUSIZ_THREE_CLOSE: begin
        copy_close = 1'b1;
        copy_med   = 1'b1;
      end
      NUSIZ_TWO_WIDE:    copy_far   = 1'b1;
      NUSIZ_DOUBLE:      width_sel  = WIDTH_2X;
      NUSIZ_THREE_MED:   begin
        copy_med = 1'b1;
        copy_far = 1'b1;
      end
      NUSIZ_QUAD:        width_sel  = WIDTH_4X;
      default:           ;
    endcase
  end

  // The main copy at count 0 is held off for the rest of the line in which
  // the object was repositioned; the extra copies are never suppressed.
  always_comb begin
    raw_start = ((position == 6'd0) && !supp)
              || (copy_close && (position == COPY_CLOSE))
              || (copy_med   && (position == COPY_MED))
              || (copy_far   && (position == COPY_FAR));
  end

endmodule

// File: rtl/tia_player_position_counter.sv
// ---------------------------------------------------------------------------
// tia_player_position_counter
// Horizontal position counter for one TIA player object. Counts enabled
// motion clocks through a 160-pixel line, opens the start_bar window for
// each drawn copy and steps the downstream graphics scan counter.
//   clock      in  1  color clock
//   reset_bar  in  1  asynchronous active-low reset
//   motck      in  1  motion-clock enable (one pixel per asserted cycle)
//   resp       in  1  RESP strobe, moves the object to count 0
//   nusiz      in  3  number/size code
//   start_bar  out 1  low while a copy-start window is open (registered)
//   pck        out 1  scan-counter step pulse (registered)
//   position   out 6  current position count, 0..39
// ---------------------------------------------------------------------------
module tia_player_position_counter
  import tia_pkg::*;
(
  input  logic       clock,
  input  logic       reset_bar,
  input  logic       motck,
  input  logic       resp,
  input  logic [2:0] nusiz,
  output logic       start_bar,
  output logic       pck,
  output logic [5:0] position
);

  localparam logic [5:0] COUNT_LAST = PLAYER_COUNT_PERIOD - 6'd1;

  logic [1:0] phase;
  logic       supp;
  logic       raw_start;
  width_t     width_sel;
  logic       pck_qualify;

  tia_player_copy_decode u_copy_decode (
    .position  (position),
    .nusiz     (nusiz),
    .supp      (supp),
    .raw_start (raw_start),
    .width_sel (width_sel)
  );

  // Wider pixels step the scan counter less often so each graphics bit is
  // held for two or four enabled clocks.
  always_comb begin
    pck_qualify = 1'b1;
    case (width_sel)
      WIDTH_2X: pck_qualify = phase[0];
      WIDTH_4X: pck_qualify = (phase == 2'd3);
      default:  pck_qualify = 1'b1;
    endcase
  end

  // Phase divider, position count and suppress flag. A RESP strobe beats
  // a coincident motion clock, including one that would wrap the line, so
  // the suppress flag survives a RESP landing on the 39->0 wrap.
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      phase    <= 2'd0;
      position <= 6'd0;
      supp     <= 1'b1;
    end else if (resp) begin
      phase    <= 2'd0;
      position <= 6'd0;
      supp     <= 1'b1;
    end else if (motck) begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        if (position == COUNT_LAST) begin
          position <= 6'd0;
          supp     <= 1'b0;
        end else begin
          position <= position + 6'd1;
        end
      end
    end
  end

  // Output registers. start_bar trails position by one cycle so a window
  // opened at a count lasts exactly as long as the count is held, and
  // stretches naturally when motck is gated. A RESP cycle is not an
  // enabled clock, so it never produces a scan-counter step.
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      start_bar <= 1'b1;
      pck       <= 1'b0;
    end else begin
      start_bar <= ~raw_start;
      pck       <= motck & ~resp & pck_qualify;
    end
  end

endmodule

// File: tb/tb_tia_player_position_counter.sv
// ---------------------------------------------------------------------------
// tb_tia_player_position_counter
// Directed self-checking bench for the player position counter. Inputs are
// driven 1 ns after a rising edge and outputs are sampled 1 ns after the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_tia_player_position_counter;

  logic       clock;
  logic       reset_bar;
  logic       motck;
  logic       resp;
  logic [2:0] nusiz;
  logic       start_bar;
  logic       pck;
  logic [5:0] position;

  int checks;
  int failures;

  // Per-run records filled by runMotck, indexed by enabled clock number.
  logic low_vec [1:340];
  int   low_count;
  int   pck_count;
  int   first_low;
  int   last_low;

  tia_player_position_counter dut (
    .clock     (clock),
    .reset_bar (reset_bar),
    .motck     (motck),
    .resp      (resp),
    .nusiz     (nusiz),
    .start_bar (start_bar),
    .pck       (pck),
    .position  (position)
  );

  // Free-running color clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and return 1 ns after the edge that used them.
  task automatic applyStimulus(input logic m, input logic r);
    motck = m;
    resp  = r;
    @(posedge clock);
    #1;
    motck = 1'b0;
    resp  = 1'b0;
  endtask

  // Apply n continuous motion clocks and record start_bar / pck activity.
  task automatic runMotck(input int n);
    low_count = 0;
    pck_count = 0;
    first_low = 0;
    last_low  = 0;
    for (int k = 1; k <= 340; k++) low_vec[k] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (pck) pck_count++;
      if (!start_bar) begin
        low_vec[k] = 1'b1;
        low_count++;
        if (first_low == 0) first_low = k;
        last_low = k;
      end
    end
  endtask

  function automatic int lowsIn(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (low_vec[k]) c++;
    return c;
  endfunction

  initial begin
    int lows;
    checks    = 0;
    failures  = 0;
    reset_bar = 1'b0;
    motck     = 1'b0;
    resp      = 1'b0;
    nusiz     = 3'b000;

    // Reset held with motion clocks running: nothing may advance.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("reset_start_bar", 32'(start_bar), 32'd1);
      checkOutput("reset_pck", 32'(pck), 32'd0);
      checkOutput("reset_position", 32'(position), 32'd0);
    end
    reset_bar = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_position", 32'(position), 32'd0);

    // Single copy: no main start in the repositioned line, 4-clock window
    // at count 0 of each later line, 160 clocks apart.
    nusiz = 3'b000;
    applyStimulus(1'b0, 1'b1);
    checkOutput("resp_position", 32'(position), 32'd0);
    runMotck(330);
    checkOutput("one_line1_lows", 32'(lowsIn(1, 160)), 32'd0);
    checkOutput("one_total_lows", 32'(low_count), 32'd8);
    checkOutput("one_first_low", 32'(first_low), 32'd161);
    checkOutput("one_last_low", 32'(last_low), 32'd324);
    checkOutput("one_pck_count", 32'(pck_count), 32'd330);
    checkOutput("one_end_position", 32'(position), 32'd2);

    // Window stretch: gated motion clocks hold count 0 and extend the window.
    applyStimulus(1'b0, 1'b1);
    runMotck(160);
    lows = 0;
    applyStimulus(1'b1, 1'b0); if (!start_bar) lows++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0); if (!start_bar) lows++;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0); if (!start_bar) lows++;
    end
    checkOutput("stretch_lows", 32'(lows), 32'd7);
    applyStimulus(1'b1, 1'b0);
    checkOutput("stretch_closed", 32'(start_bar), 32'd1);

    // Three close copies: counts 4 and 8 in line 1, then 0, 4 and 8.
    nusiz = 3'b011;
    applyStimulus(1'b0, 1'b1);
    runMotck(330);
    checkOutput("three_line1_lows", 32'(lowsIn(1, 160)), 32'd8);
    checkOutput("three_line2_lows", 32'(lowsIn(161, 320)), 32'd12);
    checkOutput("three_first_low", 32'(first_low), 32'd17);
    checkOutput("three_before_4", 32'(low_vec[16]), 32'd0);
    checkOutput("three_end_4", 32'(low_vec[20]), 32'd1);
    checkOutput("three_after_4", 32'(low_vec[21]), 32'd0);
    checkOutput("three_at_8", 32'(low_vec[33]), 32'd1);
    checkOutput("three_main_line2", 32'(low_vec[161]), 32'd1);
    checkOutput("three_after_main", 32'(low_vec[165]), 32'd0);

    // Width scaling of the scan-counter step rate over 32 enabled clocks.
    nusiz = 3'b111;
    applyStimulus(1'b0, 1'b1);
    runMotck(32);
    checkOutput("pck_quad", 32'(pck_count), 32'd8);
    nusiz = 3'b101;
    applyStimulus(1'b0, 1'b1);
    runMotck(32);
    checkOutput("pck_double", 32'(pck_count), 32'd16);
    nusiz = 3'b000;
    applyStimulus(1'b0, 1'b1);
    runMotck(32);
    checkOutput("pck_single", 32'(pck_count), 32'd32);

    // RESP on the 39->0 wrap: RESP wins and the main copy stays suppressed.
    applyStimulus(1'b0, 1'b1);
    runMotck(159);
    checkOutput("collide_pre_position", 32'(position), 32'd39);
    lows = 0;
    applyStimulus(1'b1, 1'b1);
    if (!start_bar) lows++;
    checkOutput("collide_position", 32'(position), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0); if (!start_bar) lows++;
    end
    checkOutput("collide_phase_hold", 32'(position), 32'd0);
    applyStimulus(1'b1, 1'b0); if (!start_bar) lows++;
    checkOutput("collide_phase_step", 32'(position), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0); if (!start_bar) lows++;
    end
    checkOutput("collide_no_main", 32'(lows), 32'd0);

    // Asynchronous reset in the middle of an open window.
    applyStimulus(1'b0, 1'b1);
    runMotck(162);
    checkOutput("async_window_open", 32'(start_bar), 32'd0);
    #3;
    reset_bar = 1'b0;
    #1;
    checkOutput("async_start_bar", 32'(start_bar), 32'd1);
    checkOutput("async_position", 32'(position), 32'd0);
    checkOutput("async_pck", 32'(pck), 32'd0);
    applyStimulus(1'b1, 1'b0);
    reset_bar = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_position", 32'(position), 32'd0);
    checkOutput("release_start_bar", 32'(start_bar), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("release_hold", 32'(position), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("release_advance", 32'(position), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
